// File: rtl/qei_pkg.sv
// rtl/qei_pkg.sv - shared decoder state, step encoding and Gray position helper
package qei_pkg;

   typedef enum logic {INIT = 1'b0, RUN = 1'b1} qei_state_e;

   typedef logic signed [1:0] step_t;

   localparam step_t STEP_NONE = 2'sb00;
   localparam step_t STEP_FWD  = 2'sb01;
   localparam step_t STEP_REV  = 2'sb11;

   // Index of an {A,B} pair along the forward cycle 00->01->11->10
   function automatic logic [1:0] gray_pos(input logic [1:0] ab);
      case (ab)
         2'b00:   gray_pos = 2'd0;
         2'b01:   gray_pos = 2'd1;
         2'b11:   gray_pos = 2'd2;
         default: gray_pos = 2'd3;
      endcase
   endfunction

endpackage

// File: rtl/qei_sync.sv
// rtl/qei_sync.sv - multi-flop synchroniser for one asynchronous encoder pin
module qei_sync #(
   parameter int STAGES = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr <= '0;
      end else begin
         sr <= {sr[STAGES-2:0], d};
      end
   end

   assign q = sr[STAGES-1];

endmodule

// File: rtl/qei_velocity.sv
// rtl/qei_velocity.sv - x4 quadrature decoder with windowed velocity and rpm
// Optional index input (position zeroing on idx rise) enabled by macro QEI_INDEX_EN.
module qei_velocity
   import qei_pkg::*;
#(
   parameter int POS_W         = 32,
   parameter int VEL_W         = 32,
   parameter int WINDOW_CYCLES = 100_000_000,
   parameter int SYNC_STAGES   = 3,
   parameter int RPM_MUL       = 15,
   parameter int RPM_SHIFT     = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    chA,
   input  logic                    chB,
`ifdef QEI_INDEX_EN
   input  logic                    idx,
`endif
   input  logic                    err_clr,
   output logic signed [POS_W-1:0] position,
   output logic signed [VEL_W-1:0] velocity,
   output logic signed [VEL_W-1:0] rpm,
   output logic                    dir,
   output logic                    vel_valid,
   output logic                    err
);

   localparam int TMR_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WINDOW_CYCLES - 1);
   localparam int PROD_W = VEL_W + 8;
   localparam logic signed [VEL_W-1:0] ACC_MAX = {1'b0, {(VEL_W-1){1'b1}}};
   localparam logic signed [VEL_W-1:0] ACC_MIN = {1'b1, {(VEL_W-1){1'b0}}};

   logic                     a_s;
   logic                     b_s;
   logic [1:0]               ab_cur;
   logic [1:0]               ab_prev;
   logic [1:0]               pos_diff;
   qei_state_e               state_q;
   qei_state_e               state_d;
   logic                     decode_en;
   step_t                    step;
   logic                     illegal;
   logic [TMR_W-1:0]         timer;
   logic                     terminal;
   logic signed [VEL_W-1:0]  acc;
   logic signed [VEL_W-1:0]  acc_next;
   logic signed [VEL_W-1:0]  step_v;
   logic signed [PROD_W-1:0] prod;
   logic                     zero_pos;

   qei_sync #(.STAGES(SYNC_STAGES)) u_sync_a (.clk(clk), .rst_n(rst_n), .d(chA), .q(a_s));
   qei_sync #(.STAGES(SYNC_STAGES)) u_sync_b (.clk(clk), .rst_n(rst_n), .d(chB), .q(b_s));

`ifdef QEI_INDEX_EN
   logic idx_s;
   logic idx_prev;

   qei_sync #(.STAGES(SYNC_STAGES)) u_sync_idx (.clk(clk), .rst_n(rst_n), .d(idx), .q(idx_s));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_prev <= 1'b0;
      end else begin
         idx_prev <= idx_s;
      end
   end

   assign zero_pos = idx_s & ~idx_prev;
`else
   assign zero_pos = 1'b0;
`endif

   assign ab_cur = {a_s, b_s};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= INIT;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (state_q == INIT) begin
         state_d = RUN;
      end
   end

   always_comb begin
      decode_en = (state_q == RUN);
   end

   // The previous pair is refreshed every cycle, including after an illegal jump
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ab_prev <= 2'b00;
      end else begin
         ab_prev <= ab_cur;
      end
   end

   always_comb begin
      step     = STEP_NONE;
      illegal  = 1'b0;
      pos_diff = gray_pos(ab_cur) - gray_pos(ab_prev);
      if (decode_en) begin
         case (pos_diff)
            2'd1:    step = STEP_FWD;
            2'd3:    step = STEP_REV;
            2'd2:    illegal = 1'b1;
            default: step = STEP_NONE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         position <= '0;
         dir      <= 1'b0;
         err      <= 1'b0;
      end else begin
         if (zero_pos) begin
            position <= '0;
         end else begin
            position <= position + {{(POS_W-2){step[1]}}, step};
         end
         if (step != STEP_NONE) begin
            dir <= (step == STEP_FWD);
         end
         if (illegal) begin
            err <= 1'b1;
         end else if (err_clr) begin
            err <= 1'b0;
         end
      end
   end

   assign terminal = (timer == TMR_LAST);
   assign step_v   = {{(VEL_W-2){step[1]}}, step};
   assign prod     = $signed({{8{acc[VEL_W-1]}}, acc}) * $signed(PROD_W'(RPM_MUL));

   always_comb begin
      acc_next = acc + step_v;
      if ((step == STEP_FWD && acc == ACC_MAX) || (step == STEP_REV && acc == ACC_MIN)) begin
         acc_next = acc;
      end
   end

   // The terminal-cycle step seeds the next window instead of the latched one
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer     <= '0;
         acc       <= '0;
         velocity  <= '0;
         rpm       <= '0;
         vel_valid <= 1'b0;
      end else begin
         vel_valid <= terminal;
         if (terminal) begin
            timer    <= '0;
            acc      <= step_v;
            velocity <= acc;
            rpm      <= VEL_W'(prod >>> RPM_SHIFT);
         end else begin
            timer <= timer + 1'b1;
            acc   <= acc_next;
         end
      end
   end

endmodule
